// File: rtl/approx_mul_pkg.sv
// Shared definitions for the pipelined 4-quadrant approximate multiplier.
// Quadrant indices (also the bit positions in the per-transaction mode
// vector), pipeline latency and the truncation-mask helper.
package approx_mul_pkg;

  localparam int QLL = 0;  // al * bl
  localparam int QLH = 1;  // al * bh
  localparam int QHL = 2;  // ah * bl
  localparam int QHH = 3;  // ah * bh

  localparam int APPROX_MUL_LAT = 3;

  // Keep mask: ones in bits [width-1:trunc], zeros in the truncated LSBs.
  // trunc >= width yields an all-zero mask, clearing the whole product.
  // Results wider than 64 bits are not supported (WIDTH <= 64).
  function automatic logic [63:0] trunc_mask(input int trunc, input int width);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i >= trunc) && (i < width)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_mul_pipe_if.sv
// Operand/product handshake bundle for approx_mul_pipe.
// master = producer/consumer side, slave = the multiplier.
interface approx_mul_pipe_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, prod
  );
endinterface

// File: rtl/approx_quad_mul.sv
// One H x H unsigned quadrant multiplier. When approx_en is set the TRUNC
// least-significant bits of the product are cleared. Purely combinational.
module approx_quad_mul
  import approx_mul_pkg::*;
#(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx_en,
  output logic [2*H-1:0] q
);

  localparam int QW = 2 * H;
  localparam logic [63:0]   MASK64 = trunc_mask(TRUNC, QW);
  localparam logic [QW-1:0] MASK   = MASK64[QW-1:0];

  logic [QW-1:0] full;

  // Exact product, then optional LSB truncation.
  always_comb begin
    full = QW'(x) * QW'(y);
    q    = approx_en ? (full & MASK) : full;
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// 3-stage pipelined 4-quadrant approximate multiplier with valid/ready on
// both sides. S1 registers operands+mode, S2 registers the four quadrant
// products, S3 registers the shift-add recombined product.
// Optional error statistics: define APPROX_MUL_ERR_STAT_EN to add the
// stat_clr / err_cnt / err_max ports and the exact-product side path.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,  // even, >= 4
  parameter int TRUNC = 2   // 0 .. WIDTH-1
) (
  input  logic clk,
  input  logic rst_n,
  approx_mul_pipe_if.slave bus
`ifdef APPROX_MUL_ERR_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        err_cnt,
  output logic [2*WIDTH-1:0] err_max
`endif
);

  localparam int H  = WIDTH / 2;
  localparam int QW = 2 * H;
  localparam int PW = 2 * WIDTH;

  // Whole pipe moves together; it only stalls when the output is held.
  logic advance;

  // S1 state
  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic [WIDTH-1:0] b_p1_q, b_p1_d;
  logic [3:0]       mode_p1_q, mode_p1_d;

  // S2 state
  logic                vld_p2_q, vld_p2_d;
  logic [3:0][QW-1:0]  q_p2_q, q_p2_d;

  // S3 state
  logic          vld_p3_q, vld_p3_d;
  logic [PW-1:0] prod_p3_q, prod_p3_d;

  // Quadrant operands and products between S1 and S2
  logic [3:0][H-1:0]  qx;
  logic [3:0][H-1:0]  qy;
  logic [3:0][QW-1:0] q_comb;
  logic [PW-1:0]      prod_sum;

  assign advance       = !vld_p3_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p3_q;
  assign bus.prod      = prod_p3_q;

  // ---- S1 -> S2: split operands into half-width quadrant factors ----
  always_comb begin
    qx[QLL] = a_p1_q[H-1:0];     qy[QLL] = b_p1_q[H-1:0];
    qx[QLH] = a_p1_q[H-1:0];     qy[QLH] = b_p1_q[WIDTH-1:H];
    qx[QHL] = a_p1_q[WIDTH-1:H]; qy[QHL] = b_p1_q[H-1:0];
    qx[QHH] = a_p1_q[WIDTH-1:H]; qy[QHH] = b_p1_q[WIDTH-1:H];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    approx_quad_mul #(
      .H     (H),
      .TRUNC (TRUNC)
    ) u_quad (
      .x         (qx[gi]),
      .y         (qy[gi]),
      .approx_en (mode_p1_q[gi]),
      .q         (q_comb[gi])
    );
  end

  // ---- S2 -> S3: shift-add recombination at full product width ----
  always_comb begin
    prod_sum = (PW'(q_p2_q[QHH]) << WIDTH)
             + ((PW'(q_p2_q[QHL]) + PW'(q_p2_q[QLH])) << H)
             + PW'(q_p2_q[QLL]);
  end

  // Next-state for all stages; data only loads behind a valid bit.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    mode_p1_d = mode_p1_q;
    vld_p2_d  = vld_p2_q;
    q_p2_d    = q_p2_q;
    vld_p3_d  = vld_p3_q;
    prod_p3_d = prod_p3_q;
    if (advance) begin
      vld_p1_d = bus.in_valid;
      vld_p2_d = vld_p1_q;
      vld_p3_d = vld_p2_q;
      if (bus.in_valid) begin
        a_p1_d    = bus.a;
        b_p1_d    = bus.b;
        mode_p1_d = bus.mode;
      end
      if (vld_p1_q) q_p2_d    = q_comb;
      if (vld_p2_q) prod_p3_d = prod_sum;
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      mode_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      q_p2_q    <= '0;
      vld_p3_q  <= 1'b0;
      prod_p3_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      mode_p1_q <= mode_p1_d;
      vld_p2_q  <= vld_p2_d;
      q_p2_q    <= q_p2_d;
      vld_p3_q  <= vld_p3_d;
      prod_p3_q <= prod_p3_d;
    end
  end

`ifdef APPROX_MUL_ERR_STAT_EN
  // Exact product rides alongside the approximate path through S2 and S3.
  logic [PW-1:0] exact_p2_q, exact_p2_d;
  logic [PW-1:0] exact_p3_q, exact_p3_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [PW-1:0] err_max_q, err_max_d;
  logic          out_xfer;
  logic [PW-1:0] err_diff;

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;

  // Exact side path and error statistics; clear beats an update.
  always_comb begin
    exact_p2_d = exact_p2_q;
    exact_p3_d = exact_p3_q;
    err_cnt_d  = err_cnt_q;
    err_max_d  = err_max_q;
    out_xfer   = vld_p3_q && bus.out_ready;
    err_diff   = exact_p3_q - prod_p3_q;
    if (advance) begin
      if (vld_p1_q) exact_p2_d = PW'(a_p1_q) * PW'(b_p1_q);
      if (vld_p2_q) exact_p3_d = exact_p2_q;
    end
    if (stat_clr) begin
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (out_xfer) begin
      if ((err_diff != '0) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      if (err_diff > err_max_q) err_max_d = err_diff;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_p2_q <= '0;
      exact_p3_q <= '0;
      err_cnt_q  <= '0;
      err_max_q  <= '0;
    end else begin
      exact_p2_q <= exact_p2_d;
      exact_p3_q <= exact_p3_d;
      err_cnt_q  <= err_cnt_d;
      err_max_q  <= err_max_d;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe: a driver pushes reference-model
// results when a transaction is accepted, a monitor pops and compares on
// every output transfer. Statistics ports exercised when
// APPROX_MUL_ERR_STAT_EN is defined.
module tb_approx_mul_pipe;
  import approx_mul_pkg::*;

  localparam int W  = 8;
  localparam int TR = 2;
  localparam int H  = W / 2;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] prod;
    logic [PW-1:0] exact;
    int            k;
    bit            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb[$];

  approx_mul_pipe_if #(.WIDTH(W)) bus ();

`ifdef APPROX_MUL_ERR_STAT_EN
  logic          stat_clr;
  logic [15:0]   err_cnt;
  logic [PW-1:0] err_max;
  int            m_cnt = 0;
  longint        m_max = 0;
`endif

  approx_mul_pipe #(
    .WIDTH (W),
    .TRUNC (TR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef APPROX_MUL_ERR_STAT_EN
    ,
    .stat_clr (stat_clr),
    .err_cnt  (err_cnt),
    .err_max  (err_max)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: quadrant products from plain integer arithmetic.
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [3:0] m);
    longint base, xa, ya, ah, al, bh, bl, r;
    longint qs[4];
    base = longint'(1) << H;
    xa = longint'(x);
    ya = longint'(y);
    ah = xa / base; al = xa % base;
    bh = ya / base; bl = ya % base;
    qs[0] = al * bl;
    qs[1] = al * bh;
    qs[2] = ah * bl;
    qs[3] = ah * bh;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (TR >= 2 * H) qs[i] = 0;
        else qs[i] = (qs[i] / (longint'(1) << TR)) * (longint'(1) << TR);
      end
    end
    r = qs[3] * (longint'(1) << W) + (qs[2] + qs[1]) * base + qs[0];
    return PW'(r);
  endfunction

  task automatic upd_rdy();
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic [3:0] tm, input bit lat, output bit first_try);
    int n;
    exp_t e;
    n = 0;
    bus.a = ta; bus.b = tb_; bus.mode = tm; bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk); upd_rdy(); #1; n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.prod = model(ta, tb_, tm);
      e.exact = PW'(ta) * PW'(tb_);
      e.k = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    first_try = (n == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    upd_rdy();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk); upd_rdy(); n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: looks at what will transfer on the coming rising edge.
  initial begin : monitor
    bit            hold_v;
    logic [PW-1:0] hold_p;
    exp_t          e;
    hold_v = 1'b0;
    hold_p = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_v = 1'b0;
`ifdef APPROX_MUL_ERR_STAT_EN
        m_cnt = 0; m_max = 0;
`endif
      end else begin
        chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (hold_v) begin
          chk("stall_out_valid", bus.out_valid, 1);
          chk("stall_prod", bus.prod, hold_p);
        end
        hold_v = 1'b0;
`ifdef APPROX_MUL_ERR_STAT_EN
        if (stat_clr) begin
          m_cnt = 0; m_max = 0;
        end
`endif
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", bus.prod, -1);
          end else begin
            e = sb.pop_front();
            chk("prod", bus.prod, e.prod);
            if (e.lat) chk("latency", cyc - e.k, APPROX_MUL_LAT);
`ifdef APPROX_MUL_ERR_STAT_EN
            if (!stat_clr) begin
              if (e.exact != e.prod && m_cnt < 65535) m_cnt++;
              if (longint'(e.exact) - longint'(e.prod) > m_max)
                m_max = longint'(e.exact) - longint'(e.prod);
            end
`endif
          end
        end else if (bus.out_valid) begin
          hold_v = 1'b1;
          hold_p = bus.prod;
        end
      end
    end
  end

  // Driver
  initial begin : driver
    bit ft;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.mode = '0;
    bus.out_ready = 1'b0;
`ifdef APPROX_MUL_ERR_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_prod", bus.prod, 0);
    chk("reset_in_ready", bus.in_ready, 1);
`ifdef APPROX_MUL_ERR_STAT_EN
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_err_max", err_max, 0);
`endif
    @(negedge clk);
    bus.out_ready = 1'b1;

    // Directed corner operands
    send(8'hFF, 8'hFF, 4'b0000, 1'b1, ft);
    send(8'hFF, 8'hFF, 4'b1111, 1'b1, ft);
    send(8'hFF, 8'hFF, 4'b0000, 1'b1, ft);
    drain();
    chk("const_exact", model(8'hFF, 8'hFF, 4'b0000), 65025);
`ifdef APPROX_MUL_ERR_STAT_EN
    chk("stat_err_cnt", err_cnt, 1);
    chk("stat_err_max", err_max, 289);
`endif
    send(8'hFF, 8'hFF, 4'b0001, 1'b1, ft);
    send(8'h00, 8'hFF, 4'b1111, 1'b1, ft);
    send(8'h80, 8'h01, 4'b1111, 1'b1, ft);
    drain();
`ifdef APPROX_MUL_ERR_STAT_EN
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    chk("stat_clr_cnt", err_cnt, 0);
    chk("stat_clr_max", err_max, 0);
    @(negedge clk);
`endif

    // Back-to-back burst: every transaction accepted on first try
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom), W'($urandom), 4'($urandom), 1'b1, ft);
      chk("b2b_in_ready", ft, 1);
    end
    drain();

    // Backpressure: fill pipe, stall, then release
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 4'($urandom), 1'b0, ft);
    bus.a = 8'hA5; bus.b = 8'h3C; bus.mode = 4'b1010; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(8'hA5, 8'h3C, 4'b1010, 1'b0, ft);
    drain();

    // Reset with three transactions in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hFF - 8'(i), 8'hF0, 4'b0000, 1'b0, ft);
    #1;
    chk("flight_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_prod", bus.prod, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_idle", bus.out_valid, 0);
    @(negedge clk);

    // Randomized traffic with random gaps and random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      int g;
      ra = (i % 17 == 0) ? 8'hFF : W'($urandom);
      rb = (i % 13 == 0) ? 8'h00 : W'($urandom);
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        @(negedge clk); upd_rdy();
      end
      send(ra, rb, 4'($urandom), 1'b0, ft);
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    @(negedge clk);
`ifdef APPROX_MUL_ERR_STAT_EN
    #1;
    chk("rand_err_cnt", err_cnt, m_cnt);
    chk("rand_err_max", err_max, m_max);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
